// File: rtl/ifu_fetch.sv
// Non-pipelined instruction fetch: owns the PC, keeps at most one imem request in flight and
// presents pc/inst to decode. Define IFU_MISALIGN_TRAP_EN to trap misaligned redirects.
module ifu_fetch #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jCe,
  input  logic [ADDR_W-1:0] jAddr,
  input  logic              id_ready,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              fetch_err
);

`ifdef IFU_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StDrop, StHalt} state_e;
`else
  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StDrop} state_e;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] jump_pc;
  state_e            resume_st;

`ifdef IFU_MISALIGN_TRAP_EN
  logic fetch_err_q, fetch_err_d;
  logic misalign;

  assign misalign  = jCe & (jAddr[1:0] != 2'b00);
  assign jump_pc   = jAddr;
  // Once a trap is flagged, the next point where no request is in flight parks in HALT.
  assign resume_st = (misalign || fetch_err_q) ? StHalt : StReq;
  assign fetch_err = fetch_err_q;
`else
  assign jump_pc   = jAddr & ~ADDR_W'(3);
  assign resume_st = StReq;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q  <= RESET_PC;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
`ifdef IFU_MISALIGN_TRAP_EN
      fetch_err_q <= 1'b0;
`endif
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
`ifdef IFU_MISALIGN_TRAP_EN
      fetch_err_q <= fetch_err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
`ifdef IFU_MISALIGN_TRAP_EN
    fetch_err_d = fetch_err_q | (misalign && (state_q != StHalt));
`endif
    unique case (state_q)
      StIdle: begin
        if (jCe) fetch_pc_d = jump_pc;
        state_d = resume_st;
      end
      StReq: begin
        if (jCe) begin
          fetch_pc_d = jump_pc;
          state_d    = imem_req_ready ? StDrop : resume_st;
        end else if (imem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (jCe) begin
          fetch_pc_d = jump_pc;
          state_d    = imem_rsp_valid ? resume_st : StDrop;
        end else if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          pc_d    = fetch_pc_q;
          state_d = StHold;
        end
      end
      StHold: begin
        // A redirect consumes the held instruction: it is the jump itself.
        if (jCe) begin
          fetch_pc_d = jump_pc;
          state_d    = resume_st;
        end else if (id_ready) begin
          fetch_pc_d = fetch_pc_q + ADDR_W'(4);
          state_d    = StReq;
        end
      end
      StDrop: begin
        if (jCe) fetch_pc_d = jump_pc;
        if (imem_rsp_valid) state_d = resume_st;
      end
`ifdef IFU_MISALIGN_TRAP_EN
      StHalt: state_d = StHalt;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    imem_req_valid = (state_q == StReq);
    inst_valid     = (state_q == StHold);
  end

  assign imem_addr = fetch_pc_q;
  assign pc        = pc_q;
  assign inst      = inst_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomised scoreboard bench for ifu_fetch: a transaction-level PC-stream model predicts every
// presented pc/inst pair; a memory responder returns a fixed function of the fetched address.
module tb_ifu_fetch;

`ifdef IFU_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic        clk, rst, jCe, id_ready, imem_req_ready, imem_rsp_valid;
  logic [31:0] jAddr, imem_rsp_data;
  logic        imem_req_valid, inst_valid, fetch_err;
  logic [31:0] imem_addr, pc, inst;

  ifu_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .jCe            (jCe),
    .jAddr          (jAddr),
    .id_ready       (id_ready),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .pc             (pc),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .fetch_err      (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];     // PCs decode must see next, in order
  logic [31:0] cur_pc = '0;  // expected PC of the instruction being presented
  bit          exp_err = 1'b0;
  bit          halted = 1'b0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  bit          did_rst = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom();
    if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF8 | (t & 32'h4);
    else                           t = t & 32'h0000_0FFF;
    if (TrapEn || $urandom_range(0, 7) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_checks();
    check32("rst_pc", pc, 32'h0);
    check32("rst_imem_addr", imem_addr, 32'h0);
    check32("rst_inst", inst, 32'h0);
    check32("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check32("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check32("rst_fetch_err", {31'b0, fetch_err}, 32'h0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(32'h0);
    exp_err = 1'b0;
    halted  = 1'b0;
  endtask

  // One stimulus cycle, issued just after the falling edge; the model is updated with the
  // effect the coming rising edge must have.
  task automatic drive(input bit force_j, input logic [31:0] faddr, input bit allow_j);
    logic [31:0] tgt;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pend) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        pend = 1'b0;
      end
    end else if ($urandom_range(0, 19) == 0) begin
      imem_rsp_valid = 1'b1;  // spurious pulse with nothing outstanding
      imem_rsp_data  = 32'hBAD0_0BAD;
    end
    imem_req_ready = ($urandom_range(0, 9) < 7);
    id_ready       = ($urandom_range(0, 9) < 6);
    jCe            = force_j || (allow_j && !halted && $urandom_range(0, 11) == 0);
    jAddr          = force_j ? faddr : rand_target();
    if (imem_req_valid && imem_req_ready) begin
      check32("one_outstanding", {31'b0, pend}, 32'h0);
      check32("req_align", {30'b0, imem_addr[1:0]}, 32'h0);
      pend      = 1'b1;
      pend_cnt  = $urandom_range(1, 3);
      pend_addr = imem_addr;
    end
    if (!halted) begin
      if (jCe) begin
        if (TrapEn && jAddr[1:0] != 2'b00) begin
          exp_err = 1'b1;
          halted  = 1'b1;
          exp_q.delete();
        end else begin
          tgt = jAddr & 32'hFFFF_FFFC;
          if (exp_q.size() > 0) void'(exp_q.pop_back());
          exp_q.push_back(tgt);
        end
      end else if (inst_valid && id_ready) begin
        exp_q.push_back(cur_pc + 32'd4);
      end
    end
  endtask

  // Monitor: pops the next expected PC when a new instruction appears and checks it while held.
  initial begin
    bit prev_v;
    int wd;
    prev_v = 1'b0;
    wd = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_v = 1'b0;
        wd = 0;
      end else begin
        if (inst_valid && !prev_v) begin
          wd = 0;
          if (exp_q.size() == 0) begin
            check32("unexpected_inst_pc", pc, 32'hFFFF_FFFF);
          end else begin
            cur_pc = exp_q.pop_front();
          end
        end else if (!halted) begin
          wd++;
          if (wd > 150) begin
            check32("fetch_progress_timeout", 32'd0, 32'd1);
            wd = 0;
          end
        end
        if (inst_valid) begin
          check32("pc", pc, cur_pc);
          check32("inst", inst, mem_word(cur_pc));
          check32("no_req_in_hold", {31'b0, imem_req_valid}, 32'h0);
        end
        check32("fetch_err", {31'b0, fetch_err}, {31'b0, exp_err});
        if (exp_err) begin
          check32("halt_req_valid", {31'b0, imem_req_valid}, 32'h0);
          check32("halt_inst_valid", {31'b0, inst_valid}, 32'h0);
        end
        prev_v = inst_valid;
      end
    end
  end

  initial begin
    rst = 1'b1; jCe = 1'b0; jAddr = '0; id_ready = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    #2 rst = 1'b0;
    #1 reset_checks();
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (!did_rst && i >= 1500 && pend) begin
        // Asynchronous reset while a response is pending; the stale response then arrives.
        rst = 1'b0;
        #1 reset_checks();
        pend = 1'b0;
        imem_rsp_valid = 1'b0; jCe = 1'b0; imem_req_ready = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        model_reset();
        did_rst = 1'b1;
      end else begin
        drive(1'b0, '0, 1'b1);
      end
    end
    @(negedge clk);
    #1 drive(1'b1, 32'h0000_0102, 1'b0);
    repeat (15) begin
      @(negedge clk);
      #1 drive(1'b0, '0, 1'b0);
    end
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the decode stage.
- Owns the architectural PC, issues one word fetch at a time to instruction memory, and presents the `pc`/`inst` pair to decode.
- Applies jump/branch redirects (`jCe` plus target address) with priority over sequential fetch.
- Non-pipelined: at most one outstanding memory request.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
ADDR_W, 32, width of PC and memory address.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (rst=0 resets)
jCe  input  1  redirect enable from decode
jAddr  input  ADDR_W  redirect target, valid when jCe=1
id_ready  input  1  decode accepts presented instruction this cycle
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_addr  output  ADDR_W  fetch address (word-aligned)
imem_rsp_valid  input  1  read data valid, one pulse per accepted request
imem_rsp_data  input  32  instruction word
pc  output  ADDR_W  PC of presented instruction
inst  output  32  presented instruction
inst_valid  output  1  pc/inst valid for decode
fetch_err  output  1  misaligned redirect flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, imem_addr=RESET_PC, inst=0.
  - inst_valid=0, imem_req_valid=0, fetch_err=0.
  - State=IDLE; any in-flight response is forgotten.
- Internal registers: state, fetch_pc (address being fetched).
- States:
  - IDLE: outputs idle; next cycle -> REQ. Exists only after reset.
  - REQ: imem_req_valid=1, imem_addr=fetch_pc. On imem_req_ready=1 -> WAIT.
  - WAIT: request accepted, response pending. On imem_rsp_valid=1: latch inst=imem_rsp_data, pc=fetch_pc -> HOLD.
  - HOLD: inst_valid=1. On id_ready=1: fetch_pc=fetch_pc+4 (mod 2^ADDR_W, wraps 32'hFFFF_FFFC -> 0) -> REQ.
  - DROP: a redirected request is still outstanding. On imem_rsp_valid=1: discard data -> REQ.
- Redirect (jCe=1) has priority over all sequential transitions and always loads fetch_pc=jAddr:
  - IDLE or HOLD: -> REQ; the held instruction is treated as consumed (it is the jump); inst_valid drops next cycle.
  - REQ with imem_req_ready=0: stay REQ; imem_addr changes to jAddr next cycle. The memory contract permits changing an unaccepted address.
  - REQ with imem_req_ready=1: the old request was accepted -> DROP.
  - WAIT with imem_rsp_valid=0: -> DROP.
  - WAIT with imem_rsp_valid=1 in the same cycle: response discarded -> REQ.
  - DROP: stay DROP, or -> REQ if imem_rsp_valid=1 in the same cycle.
- No branch delay slot.
- Latency: accept in cycle N, response at N+k (k≥1), inst_valid at N+k+1.
- Best-case steady throughput: one instruction per 3 cycles.
- inst/pc change only on HOLD entry and are stable while inst_valid=1.
- imem_rsp_valid outside WAIT/DROP is ignored.

Optional Feature:
- Macro: IFU_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with jAddr[1:0]≠0 sets fetch_err=1 (sticky until reset) and moves to a HALT state.
  - HALT: imem_req_valid=0, inst_valid=0, all inputs ignored.
  - A redirect arriving while a request is outstanding still waits in DROP for the response before HALT.
- Undefined:
  - jAddr[1:0] is forced to 0 when loaded.
  - fetch_err is tied 0; no HALT state.

Test Plan:
1. Reset release, RESET_PC=0, ready=1, rsp 1 cycle after accept, id_ready=1 -> imem_addr 0,4,8 in sequence; inst_valid pulses show pc=0,4,8 with matching inst.
2. id_ready=0 for 5 cycles in HOLD -> pc/inst stable, inst_valid=1 held, no new imem_req_valid.
3. jCe=1, jAddr=32'h100 while in HOLD at pc=8 -> next request addr 32'h100; no inst for pc=12 is presented.
4. jCe=1, jAddr=32'h200 in WAIT, response (0xDEADBEEF) 3 cycles later -> 0xDEADBEEF never presented; next request addr 32'h200.
5. Fetch at 32'hFFFF_FFFC consumed -> next imem_addr=0.
6. Assert rst=0 mid-WAIT, then release -> outputs at reset values immediately; the stale response is ignored; fetch restarts at RESET_PC. With IFU_MISALIGN_TRAP_EN, jAddr=32'h102 -> fetch_err=1 and imem_req_valid stays 0.
